lif_neuron_array: RTL
=====================

Name: lif_neuron_array

Overview:
- Parametrised successor to the single spiking neuron: N independent leaky integrate-and-fire (LIF) neurons in parallel.
- Adds per-neuron leak, programmable threshold, saturating integration, refractory period, global enable and a membrane-potential monitor port.
- Sits between the top-level input pins (per-neuron input current) and the spike outputs of the tiny SNN top level.

Parameters:
- N, 4, number of neurons.
- IN_W, 8, width of each neuron's unsigned input current.
- V_W, 10, membrane potential width, unsigned; must be > IN_W.
- LEAK_SHIFT, 3, leak = V >> LEAK_SHIFT per active cycle; legal range 1..V_W-1.
- REFRAC, 2, refractory cycles after a spike; 0 disables refractory.
- CNT_W, 16, spike counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global update enable.
- threshold  in  V_W  firing threshold, shared by all neurons, sampled every cycle.
- neuron_input  in  N*IN_W  input current; neuron k uses bits [k*IN_W +: IN_W].
- mon_sel  in  clog2(N) (min 1)  selects the neuron shown on mon_potential.
- mon_potential  out  V_W  combinational view of V[mon_sel]; 0 if mon_sel >= N.
- spike  out  N  registered spike flags, one per neuron.
- spike_count  out  CNT_W  total spike count (optional feature).

Behaviour:
- Per-neuron state: V[k] (V_W bits) and ref[k] (clog2(REFRAC+1) bits; none when REFRAC = 0).
- Reset (rst_n low, async): all V = 0, all ref = 0, spike = 0, spike_count = 0. Mid-operation reset clears everything immediately; the first update follows the first rising edge with rst_n high.
- en low: V, ref and spike_count hold; spike forced to 0 on the next edge.
- en high, ref[k] > 0 (refractory): ref[k] decrements, V[k] stays 0, input is ignored, spike[k] = 0.
- en high, ref[k] = 0:
  - leaked = V - (V >> LEAK_SHIFT), never negative.
  - sum = leaked + input, computed in V_W+1 bits and saturated to 2^V_W - 1.
  - If sum >= threshold: spike[k] <= 1, V[k] <= 0, ref[k] <= REFRAC.
  - Otherwise: spike[k] <= 0, V[k] <= sum.
- Latency: spike[k] goes high on the same edge that registers the threshold crossing, is high for exactly one cycle per firing, and cannot be high on two consecutive cycles when REFRAC > 0.
- threshold = 0: every non-refractory enabled cycle fires.
- Saturation is applied before the compare; V never wraps.
- Neurons are fully independent; no lateral coupling.

Optional Feature:
- Macro: LIF_SPIKE_COUNT_EN.
- Defined: spike_count increments on each edge by popcount of the spike vector being registered on that edge. It saturates at 2^CNT_W - 1, holds while en is low, and is cleared only by reset.
- Undefined: port remains for interface stability but is tied to 0, and no counter logic is built.

Test Plan:
(N=4, IN_W=8, V_W=10, LEAK_SHIFT=3, REFRAC=2 unless noted)
- Basic fire: threshold=200, input0=100, others 0, en=1 -> V0 = 100, 188, then spike[0]=1 on the 3rd edge with V0=0; spike[3:1] stay 0.
- Refractory: continue the previous case -> spike[0]=0 and V0=0 for 2 edges; V0=100 on the 3rd edge after the spike; spike[0] on the 3rd edge after that; period 5 cycles.
- Saturation: threshold=1023, input0=255 -> V0 = 255, 479, 675, 846, 996; sum 1127 saturates to 1023, so spike[0]=1 on the 6th edge; mon_potential never shows a wrapped value.
- Enable/threshold edges: en=0 with V0=188 -> V0 holds 188 and spike=0 across 5 edges. threshold=0 with en=1 -> all neurons fire on the next edge, then obey refractory.
- Async reset mid-run: assert rst_n low between edges while V0=188 -> V0, spike and ref are 0 immediately without waiting for a clock edge; after release, the sequence restarts from V=0.
- Counter (macro defined): all 4 inputs=255, threshold=1 -> spike=4'hF on edge 1, spike_count=4; with CNT_W=3, the count saturates at 7. Macro undefined -> spike_count stays 0.

Source files
------------

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N independent leaky integrate-and-fire neurons.
// Each neuron leaks V >> LEAK_SHIFT per enabled cycle and adds its input
// current with saturation. It fires when the saturated sum reaches the shared
// threshold, then stays silent for REFRAC cycles.
// Optional feature: define LIF_SPIKE_COUNT_EN to build a saturating total
// spike counter. When it is undefined, spike_count is tied to 0.
module lif_neuron_array #(
  parameter int N          = 4,
  parameter int IN_W       = 8,
  parameter int V_W        = 10,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [V_W-1:0]      threshold,
  input  logic [N*IN_W-1:0]   neuron_input,
  input  logic [SEL_W-1:0]    mon_sel,
  output logic [V_W-1:0]      mon_potential,
  output logic [N-1:0]        spike,
  output logic [CNT_W-1:0]    spike_count
);

  localparam int REF_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  // Membrane potentials of all neurons, gathered for the monitor mux.
  logic [N-1:0][V_W-1:0] v_all;
`ifdef LIF_SPIKE_COUNT_EN
  // Spikes being registered on the coming edge, used by the counter.
  logic [N-1:0] fire_vec;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_neuron
      logic [V_W-1:0]  v_reg;
      logic            spike_reg;
      logic [IN_W-1:0] cur;
      logic [V_W-1:0]  leaked;
      logic [V_W:0]    sum;
      logic [V_W-1:0]  sat;
      logic            refractory;
      logic            fire;

      assign cur    = neuron_input[gi*IN_W +: IN_W];
      // The shifted value never exceeds v_reg, so this cannot underflow.
      assign leaked = v_reg - (v_reg >> LEAK_SHIFT);
      // One extra bit catches the overflow, which then clamps to full scale.
      assign sum    = {1'b0, leaked} + {{(V_W + 1 - IN_W){1'b0}}, cur};
      assign sat    = sum[V_W] ? {V_W{1'b1}} : sum[V_W-1:0];
      assign fire   = en && !refractory && (sat >= threshold);

      if (REFRAC > 0) begin : g_ref
        logic [REF_W-1:0] ref_reg;
        // Refractory countdown: loaded on a firing, counts down while enabled.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ref_reg <= '0;
          end else if (en) begin
            if (ref_reg != '0) begin
              ref_reg <= ref_reg - REF_W'(1);
            end else if (fire) begin
              ref_reg <= REF_W'(REFRAC);
            end
          end
        end
        assign refractory = (ref_reg != '0);
      end else begin : g_noref
        assign refractory = 1'b0;
      end

      // Membrane and spike update: fire or refractory clears V, else integrate.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg     <= '0;
          spike_reg <= 1'b0;
        end else begin
          spike_reg <= fire;
          if (en) begin
            if (refractory || fire) begin
              v_reg <= '0;
            end else begin
              v_reg <= sat;
            end
          end
        end
      end

      assign v_all[gi] = v_reg;
      assign spike[gi] = spike_reg;
`ifdef LIF_SPIKE_COUNT_EN
      assign fire_vec[gi] = fire;
`endif
    end
  endgenerate

  // Monitor mux: selected neuron's potential, or 0 for an out-of-range select.
  always_comb begin
    mon_potential = '0;
    for (int k = 0; k < N; k++) begin
      if (mon_sel == SEL_W'(k)) begin
        mon_potential = v_all[k];
      end
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  localparam int PC_W  = $clog2(N + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_reg;

  // Population count of the spikes being registered this edge.
  always_comb begin
    pop = '0;
    for (int k = 0; k < N; k++) begin
      pop = pop + PC_W'(fire_vec[k]);
    end
  end

  assign cnt_sum = SUM_W'(cnt_reg) + SUM_W'(pop);

  // Saturating spike counter. It holds while disabled and only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (cnt_sum > SUM_W'({CNT_W{1'b1}})) begin
        cnt_reg <= '1;
      end else begin
        cnt_reg <= cnt_sum[CNT_W-1:0];
      end
    end
  end

  assign spike_count = cnt_reg;
`else
  assign spike_count = '0;
`endif

endmodule
